// File: rtl/result_gather_pkg.sv
// Shared definitions for the result gather block: FSM states, default
// geometry and the width of child/read indices.
package result_gather_pkg;

  localparam int NUM_CHILDREN_DEF = 6;
  localparam int WIDTH_DEF        = 32;
  localparam int IDX_W            = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_DONE    = 2'd2
  } gather_state_e;

endpackage

// File: rtl/result_gather.sv
// Result gather: latches one result pair from each child core the first
// time its flag is seen, then walks the captured entries to find the
// child with the smallest word 1 (lowest index wins ties).
module result_gather
  import result_gather_pkg::*;
#(
  parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int WIDTH        = WIDTH_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_CHILDREN-1:0]       child_flag,
  input  logic [NUM_CHILDREN*WIDTH-1:0] child_val_1,
  input  logic [NUM_CHILDREN*WIDTH-1:0] child_val_2,
  input  logic                          clear,
  input  logic [IDX_W-1:0]              rd_addr_1,
  input  logic [IDX_W-1:0]              rd_addr_2,
  output logic [WIDTH-1:0]              rd_val_1,
  output logic [WIDTH-1:0]              rd_val_2,
  output logic                          all_done,
  output logic [WIDTH-1:0]              best_val_1,
  output logic [WIDTH-1:0]              best_val_2,
  output logic [IDX_W-1:0]              best_idx,
  output logic                          best_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_CHILDREN);

  gather_state_e          r_state;
  logic [NUM_CHILDREN-1:0] r_captured;
  logic [WIDTH-1:0]       r_val_1 [NUM_CHILDREN];
  logic [WIDTH-1:0]       r_val_2 [NUM_CHILDREN];
  logic                   r_all_done;
  logic [WIDTH-1:0]       r_best_val_1;
  logic [WIDTH-1:0]       r_best_val_2;
  logic [IDX_W-1:0]       r_best_idx;
  logic                   r_best_valid;
  logic [IDX_W-1:0]       r_scan_idx;

  logic                   w_addr_1_ok;
  logic                   w_addr_2_ok;

  assign w_addr_1_ok = ({1'b0, rd_addr_1} < NUM_EXT);
  assign w_addr_2_ok = ({1'b0, rd_addr_2} < NUM_EXT);

  // Capture storage: first flagged edge per child latches both words; sticky until clear/reset.
  always_ff @(posedge Clk) begin
    if (!Reset || clear) begin
      r_captured <= '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        r_val_1[i] <= '0;
        r_val_2[i] <= '0;
      end
    end else if (r_state == ST_COLLECT) begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        if (child_flag[i] && !r_captured[i]) begin
          r_captured[i] <= 1'b1;
          r_val_1[i]    <= child_val_1[i*WIDTH +: WIDTH];
          r_val_2[i]    <= child_val_2[i*WIDTH +: WIDTH];
        end else begin
          r_captured[i] <= r_captured[i];
          r_val_1[i]    <= r_val_1[i];
          r_val_2[i]    <= r_val_2[i];
        end
      end
    end else begin
      r_captured <= r_captured;
    end
  end

  // Completion flag: registered AND of the capture bits, one edge behind the last capture.
  always_ff @(posedge Clk) begin
    if (!Reset || clear) begin
      r_all_done <= 1'b0;
    end else begin
      r_all_done <= &r_captured;
    end
  end

  // Scan FSM: seed best from entry 0, then fold in entries 1..N-1 with a strict unsigned compare.
  always_ff @(posedge Clk) begin
    if (!Reset || clear) begin
      r_state      <= ST_COLLECT;
      r_scan_idx   <= '0;
      r_best_val_1 <= '0;
      r_best_val_2 <= '0;
      r_best_idx   <= '0;
      r_best_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (&r_captured) begin
            r_state      <= ST_SCAN;
            r_best_val_1 <= r_val_1[0];
            r_best_val_2 <= r_val_2[0];
            r_best_idx   <= '0;
            r_scan_idx   <= IDX_W'(1);
          end else begin
            r_state <= ST_COLLECT;
          end
        end
        ST_SCAN: begin
          // Strict less-than keeps the earlier (lower) index on ties.
          if (r_val_1[r_scan_idx] < r_best_val_1) begin
            r_best_val_1 <= r_val_1[r_scan_idx];
            r_best_val_2 <= r_val_2[r_scan_idx];
            r_best_idx   <= r_scan_idx;
          end else begin
            r_best_idx <= r_best_idx;
          end
          if (r_scan_idx == LAST_IDX) begin
            r_state      <= ST_DONE;
            r_best_valid <= 1'b1;
          end else begin
            r_state <= ST_SCAN;
          end
          r_scan_idx <= r_scan_idx + IDX_W'(1);
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state      <= ST_COLLECT;
          r_best_valid <= 1'b0;
        end
      endcase
    end
  end

  // Read ports: out-of-range or uncaptured addresses read as zero.
  always_comb begin
    rd_val_1 = '0;
    rd_val_2 = '0;
    if (w_addr_1_ok && r_captured[rd_addr_1]) begin
      rd_val_1 = r_val_1[rd_addr_1];
    end else begin
      rd_val_1 = '0;
    end
    if (w_addr_2_ok && r_captured[rd_addr_2]) begin
      rd_val_2 = r_val_2[rd_addr_2];
    end else begin
      rd_val_2 = '0;
    end
  end

  assign all_done   = r_all_done;
  assign best_val_1 = r_best_val_1;
  assign best_val_2 = r_best_val_2;
  assign best_idx   = r_best_idx;
  assign best_valid = r_best_valid;

endmodule

// File: tb/tb_result_gather.sv
// Self-checking bench for result_gather with a per-edge behavioural model.
module tb_result_gather;
  localparam int N = 6;
  localparam int W = 32;

  logic           Clk;
  logic           Reset;
  logic [N-1:0]   child_flag;
  logic [N*W-1:0] child_val_1;
  logic [N*W-1:0] child_val_2;
  logic           clear;
  logic [2:0]     rd_addr_1;
  logic [2:0]     rd_addr_2;
  logic [W-1:0]   rd_val_1;
  logic [W-1:0]   rd_val_2;
  logic           all_done;
  logic [W-1:0]   best_val_1;
  logic [W-1:0]   best_val_2;
  logic [2:0]     best_idx;
  logic           best_valid;

  result_gather #(.NUM_CHILDREN(N), .WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .child_flag(child_flag),
    .child_val_1(child_val_1), .child_val_2(child_val_2), .clear(clear),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_val_1(rd_val_1), .rd_val_2(rd_val_2), .all_done(all_done),
    .best_val_1(best_val_1), .best_val_2(best_val_2),
    .best_idx(best_idx), .best_valid(best_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: captured flags, held words, edges elapsed since the set became full (-1 = not full).
  bit             m_cap [N];
  logic [W-1:0]   m_v1  [N];
  logic [W-1:0]   m_v2  [N];
  int             m_since = -1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_child(input int i, input logic [W-1:0] v1, input logic [W-1:0] v2);
    child_val_1[i*W +: W] = v1;
    child_val_2[i*W +: W] = v2;
  endtask

  // Winner: the smallest word 1, and among equals the first index holding it.
  task automatic model_best(output logic [W-1:0] b1, output logic [W-1:0] b2, output int bi);
    logic [W-1:0] mn;
    mn = m_v1[0];
    foreach (m_v1[i]) if (m_v1[i] < mn) mn = m_v1[i];
    bi = 0;
    for (int i = N - 1; i >= 0; i--) if (m_v1[i] == mn) bi = i;
    b1 = m_v1[bi];
    b2 = m_v2[bi];
  endtask

  task automatic model_edge();
    bit full;
    if (!Reset || clear) begin
      foreach (m_cap[i]) begin m_cap[i] = 0; m_v1[i] = '0; m_v2[i] = '0; end
      m_since = -1;
    end else if (m_since < 0) begin
      full = 1;
      for (int i = 0; i < N; i++) begin
        if (child_flag[i] && !m_cap[i]) begin
          m_cap[i] = 1;
          m_v1[i]  = child_val_1[i*W +: W];
          m_v2[i]  = child_val_2[i*W +: W];
        end
        if (!m_cap[i]) full = 0;
      end
      if (full) m_since = 0;
    end else if (m_since < 1000) begin
      m_since++;
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1 ns later.
  task automatic tick();
    logic [W-1:0] b1, b2, e1, e2;
    int bi;
    @(posedge Clk);
    model_edge();
    #1;
    e1 = (rd_addr_1 < 3'(N) && m_cap[rd_addr_1]) ? m_v1[rd_addr_1] : '0;
    e2 = (rd_addr_2 < 3'(N) && m_cap[rd_addr_2]) ? m_v2[rd_addr_2] : '0;
    chk("rd_val_1", rd_val_1, e1);
    chk("rd_val_2", rd_val_2, e2);
    chk("all_done", W'(all_done), W'(m_since >= 1));
    chk("best_valid", W'(best_valid), W'(m_since >= N));
    if (m_since >= N) begin
      model_best(b1, b2, bi);
      chk("best_val_1", best_val_1, b1);
      chk("best_val_2", best_val_2, b2);
      chk("best_idx", W'(best_idx), W'(bi));
    end else if (m_since < 1) begin
      chk("best_val_1_zero", best_val_1, '0);
      chk("best_idx_zero", W'(best_idx), '0);
    end
  endtask

  task automatic run_to_valid(input string tag);
    int budget;
    budget = 0;
    while (m_since < N + 1 && budget < 60) begin
      tick();
      budget++;
    end
    chk({tag, "_timeout"}, W'(m_since >= N + 1), W'(1));
  endtask

  initial begin
    logic [W-1:0] vals [N];
    Reset = 1'b0; clear = 1'b0; child_flag = '0;
    child_val_1 = '0; child_val_2 = '0; rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;

    // Reset state
    tick(); tick();
    chk("reset_all_done", W'(all_done), '0);
    chk("reset_best_valid", W'(best_valid), '0);
    Reset = 1'b1;
    tick();

    // All six flagged together, tie on 20 between children 1 and 3
    vals = '{32'd50, 32'd20, 32'd70, 32'd20, 32'd90, 32'd30};
    for (int i = 0; i < N; i++) set_child(i, vals[i], W'(100 + i));
    child_flag = '1;
    rd_addr_1 = 3'd3; rd_addr_2 = 3'd1;
    tick();
    chk("burst_not_done_yet", W'(all_done), '0);
    tick();
    chk("burst_done_1cyc", W'(all_done), W'(1));
    for (int k = 0; k < 4; k++) tick();
    chk("burst_not_valid_5", W'(best_valid), '0);
    tick();
    chk("burst_valid_6", W'(best_valid), W'(1));
    chk("tie_idx_const", W'(best_idx), W'(1));
    chk("tie_val_const", best_val_1, W'(20));
    rd_addr_1 = 3'd7;
    tick();
    chk("oob_read", rd_val_1, '0);

    // Staggered flags 5..0; child 4 changes after capture
    clear = 1'b1; child_flag = '0;
    tick();
    clear = 1'b0; rd_addr_1 = 3'd4; rd_addr_2 = 3'd0;
    for (int i = 0; i < N; i++) set_child(i, W'(1000 - 7 * i), $urandom);
    for (int i = N - 1; i >= 0; i--) begin
      child_flag[i] = 1'b1;
      tick();
      if (i == 4) set_child(4, W'(1), W'(2));
    end
    chk("sticky_child4", rd_val_1, W'(1000 - 28));
    run_to_valid("stagger");

    // Uncaptured read
    clear = 1'b1; child_flag = '0;
    tick();
    clear = 1'b0; child_flag = 6'b000001; rd_addr_1 = 3'd2;
    tick();
    chk("uncaptured_read", rd_val_1, '0);

    // Clear during SCAN at index 3, flags held high are recaptured
    child_flag = '1;
    for (int i = 0; i < N; i++) set_child(i, W'(40 - i), $urandom);
    while (m_since < 4) tick();
    clear = 1'b1;
    tick();
    chk("clr_scan_done", W'(all_done), '0);
    chk("clr_scan_valid", W'(best_valid), '0);
    clear = 1'b0;
    set_child(2, W'(3), W'(33));
    run_to_valid("after_clear");
    chk("after_clear_idx_const", W'(best_idx), W'(2));

    // Reset in DONE with clear and a flag asserted together
    child_flag = 6'b000100; clear = 1'b1; Reset = 1'b0; rd_addr_1 = 3'd2;
    tick();
    chk("rst_done_best", best_val_1, '0);
    Reset = 1'b1; clear = 1'b0; child_flag = '0;
    tick();
    chk("rst_nothing_captured", rd_val_1, '0);

    // Unsigned compare around the sign bit
    set_child(0, 32'hFFFF_FFFF, 32'd1);
    set_child(1, 32'h8000_0000, 32'd2);
    set_child(2, 32'h7FFF_FFFF, 32'd3);
    set_child(3, 32'hFFFF_FFFE, 32'd4);
    set_child(4, 32'h8000_0001, 32'd5);
    set_child(5, 32'h9000_0000, 32'd6);
    child_flag = '1;
    run_to_valid("unsigned");
    chk("unsigned_const", best_val_1, 32'h7FFF_FFFF);

    // Randomized rounds with small values for frequent ties
    for (int r = 0; r < 12; r++) begin
      clear = 1'b1; child_flag = '0;
      tick();
      clear = 1'b0;
      for (int i = 0; i < N; i++) set_child(i, W'($urandom_range(0, 15)), $urandom);
      for (int c = 0; c < 60 && m_since < N + 1; c++) begin
        for (int i = 0; i < N; i++) child_flag[i] = ($urandom_range(0, 9) < 3) || (c > 20);
        if ($urandom_range(0, 3) == 0) set_child($urandom_range(0, N - 1), W'($urandom_range(0, 15)), $urandom);
        rd_addr_1 = 3'($urandom_range(0, 7));
        rd_addr_2 = 3'($urandom_range(0, 7));
        clear = (r % 3 == 1) && (c == 4);
        tick();
      end
      chk("rand_round_valid", W'(best_valid), W'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/result_gather.md
RESULT_GATHER -- requirements
Module: result_gather

Interface
REQ-001 SHALL have parameter NUM_CHILDREN, default 6; number of child cores served, range 2..8.
REQ-002 SHALL have parameter WIDTH, default 32; width of each child result word.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port child_flag, input, NUM_CHILDREN: per-child "result ready" level.
REQ-006 SHALL have port child_val_1, input, NUM_CHILDREN*WIDTH: child i result word 1 in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port child_val_2, input, NUM_CHILDREN*WIDTH: child i result word 2, packed the same way.
REQ-008 SHALL have port clear, input, 1: synchronous restart of a gather round.
REQ-009 SHALL have ports rd_addr_1 and rd_addr_2, input, 3 each: parent read indices.
REQ-010 SHALL have ports rd_val_1 and rd_val_2, output, WIDTH each: captured word 1 at rd_addr_1 and captured word 2 at rd_addr_2.
REQ-011 SHALL have port all_done, output, 1: every child result captured.
REQ-012 SHALL have port best_val_1, output, WIDTH: minimum captured word 1.
REQ-013 SHALL have port best_val_2, output, WIDTH: word 2 of the winning child.
REQ-014 SHALL have port best_idx, output, 3: index of the winning child.
REQ-015 SHALL have port best_valid, output, 1: best_* outputs are final.

Function
REQ-016 SHALL capture both words of child i on the first rising edge with child_flag[i]=1 and captured[i]=0, then set captured[i].
REQ-017 SHALL hold captured entries sticky: later flag toggles or value changes SHALL be ignored until clear or reset.
REQ-018 SHALL capture any subset of children in the same cycle, including all NUM_CHILDREN at once.
REQ-019 SHALL drive rd_val_1 and rd_val_2 combinationally from the capture registers.
REQ-020 SHALL return 0 on a read of an address >= NUM_CHILDREN or of an uncaptured entry.
REQ-021 SHALL drive all_done = AND of all captured bits, registered, so it rises one cycle after the last capture edge.
REQ-022 SHALL implement an FSM with states COLLECT, SCAN and DONE.
REQ-023 COLLECT -> SCAN SHALL occur on the first edge with all_done=1; that edge loads best from entry 0 and sets scan index 1.
REQ-024 Each SCAN edge SHALL compare entry k as an unsigned value; if its word 1 < best_val_1 (strict), best SHALL be replaced; the index SHALL then increment.
REQ-025 SCAN -> DONE SHALL occur on the edge that processes index NUM_CHILDREN-1.
REQ-026 best_valid SHALL be 1 only in DONE, i.e. NUM_CHILDREN edges after the last capture edge.
REQ-027 On equal word 1 values the lowest index SHALL win.
REQ-028 DONE SHALL hold all outputs stable until clear.
REQ-029 clear=1 SHALL, on that edge and from any state, zero the captured bits, the entries, all_done, best_* and best_valid, and enter COLLECT.
REQ-030 clear SHALL override a capture in the same cycle: flags asserted during the clear edge are captured on the next edge if still high.
REQ-031 In SCAN and DONE the inputs SHALL not be recaptured, since all entries are already held.

Reset
REQ-032 Reset=0 at a rising edge SHALL have the effect of clear and SHALL take priority over clear and capture, including mid-SCAN.
REQ-033 After reset all outputs SHALL be 0 and the state SHALL be COLLECT.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (COLLECT, SCAN, DONE), the default NUM_CHILDREN, WIDTH, and the 3-bit index width constant.
REQ-035 The block SHALL be flat, with no sub-module; capture storage and the scan comparator live in result_gather.
REQ-036 One result_gather per parent core SHALL sit between the child cores and that parent, replacing the direct select and flag-AND logic.

Verification
REQ-037 Child val_1 = {50,20,70,20,90,30} all flagged in one cycle -> all_done after 1 cycle; best_valid after 6 cycles; best_val_1=20, best_idx=1 (tie with child 3 won by lowest index).
REQ-038 Flags rise one per cycle in order 5,4,3,2,1,0; child 4 changes its val_1 after capture -> rd_val_1 at addr 4 returns the original value; all_done rises one cycle after child 0 is captured.
REQ-039 Read rd_addr_1=7 with NUM_CHILDREN=6 -> rd_val_1=0; read an uncaptured index -> 0.
REQ-040 clear asserted during SCAN (index 3) -> next cycle state=COLLECT, best_valid=0, all_done=0; held-high flags are recaptured, and a new scan returns the correct minimum.
REQ-041 Reset=0 for one cycle in DONE -> all outputs 0; a clear and a flag asserted together with Reset -> nothing captured.
REQ-042 Child val_1 = {0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, ...} -> unsigned compare selects 0x7FFFFFFF or smaller, never 0x80000000.
